register_mapper_param: RTL and testbench
========================================

// Module: register_mapper_param
// PURPOSE
//  Parametrised logical-to-physical register mapping table for the processor decode stage.
//  Holds a permutation of NUM_REGS physical indices and answers two lookups every cycle.
//  Accepts commands on a valid/ready handshake:
//   - SWAP: exchange two entries.
//   - SAVE / RESTORE: one-deep checkpoint of the whole table.
//   - CLEAR: multi-cycle walk that returns the table to identity.
//  Keeps a saturating count of performed swaps.
// PARAMETERS
//  NUM_REGS  4                         number of logical/physical registers (>=2, power of 2)
//  IDX_W     $clog2(NUM_REGS)          width of a register index (derived, do not override)
//  CNT_W     8                         width of swap_count
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  cmd_valid    in   1      command present
//  cmd_ready    out  1      block can accept a command this cycle
//  cmd_op       in   2      00 SWAP, 01 SAVE, 10 RESTORE, 11 CLEAR
//  cmd_reg_a    in   IDX_W  SWAP operand A (ignored for other ops)
//  cmd_reg_b    in   IDX_W  SWAP operand B (ignored for other ops)
//  lkp1_reg     in   IDX_W  lookup port 1 logical index
//  lkp1_mapped  out  IDX_W  table[lkp1_reg]
//  lkp2_reg     in   IDX_W  lookup port 2 logical index
//  lkp2_mapped  out  IDX_W  table[lkp2_reg]
//  busy         out  1      CLEAR walk in progress
//  swap_count   out  CNT_W  number of SWAPs performed, saturating
// BEHAVIOUR
//  Reset (async assert):
//   - table[i]=i and ckpt[i]=i for all i; FSM=IDLE.
//   - cmd_ready=1, busy=0, swap_count=0.
//  Lookups: combinational from the registered table, zero latency.
//   Same-cycle commands are not visible until the next cycle (no bypass).
//  Handshake: a command is accepted on a rising edge where cmd_valid && cmd_ready.
//   cmd_ready = (FSM==IDLE).
//  FSM states: IDLE, CLEARING.
//  IDLE, accepted command, applied at that edge:
//   - SWAP, a!=b:
//     * table[a]<=table[b] and table[b]<=table[a], both reading pre-edge values.
//     * swap_count += 1, saturating at 2^CNT_W-1.
//   - SWAP, a==b: table unchanged, swap_count unchanged (no-op, still accepted).
//   - SAVE: ckpt <= table (all entries, one cycle).
//   - RESTORE: table <= ckpt (all entries, one cycle); swap_count unchanged.
//   - CLEAR: go to CLEARING with walk index ptr=0; ckpt and swap_count untouched.
//  CLEARING:
//   - Each cycle: table[ptr] <= ptr, then ptr += 1.
//   - On the cycle ptr==NUM_REGS-1, write that entry and return to IDLE.
//   - CLEAR occupies NUM_REGS cycles; cmd_ready=0 and busy=1 for exactly those cycles.
//   - Lookups during CLEARING return the partially cleared table (entries < ptr already identity).
//   - Commands presented while cmd_ready=0 are ignored; the master holds them.
//  Table is a permutation at all times: every SWAP, RESTORE and completed CLEAR preserves this.
//  Reset asserted mid-CLEAR: immediate identity table and IDLE; no partial state survives.
//  Unused op encodings: none; all 4 are defined.
// TESTING
//  - Reset -> lkp1_reg=0..3 gives 0..3, cmd_ready=1, busy=0, swap_count=0.
//  - SWAP(1,3), then SWAP(0,1) -> table={3,0,2,1}, swap_count=2; lookups show the change 1 cycle after each accept.
//  - SWAP(2,2) -> table unchanged, swap_count unchanged, cmd_ready stays 1.
//  - SAVE at {3,0,2,1}, SWAP(0,3), RESTORE -> table={3,0,2,1}.
//  - CLEAR from {3,0,2,1} -> busy high 4 cycles; table[0]=0 after first cycle; SWAP held valid is accepted only after busy falls.
//  - CNT_W=2, 5 SWAPs with a!=b -> swap_count=3; reset asserted mid-CLEAR -> identity table, busy=0 asynchronously.

Source files
------------

// File: rtl/register_mapper_param.sv
// Logical-to-physical register mapping table with two zero-latency lookup ports,
// SWAP / SAVE / RESTORE commands and a multi-cycle CLEAR walk back to identity.

module register_mapper_entry #(
    parameter int               IDX_W     = 2,
    parameter logic [IDX_W-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tbl_we,
    input  logic [IDX_W-1:0] tbl_d,
    input  logic             ckpt_we,
    output logic [IDX_W-1:0] tbl_q,
    output logic [IDX_W-1:0] ckpt_q
);
    // Live mapping and checkpoint copy share one reset value: the entry's own index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tbl_q  <= RESET_VAL;
            ckpt_q <= RESET_VAL;
        end else begin
            if (tbl_we)  tbl_q  <= tbl_d;
            if (ckpt_we) ckpt_q <= tbl_q;
        end
    end
endmodule

module register_mapper_param #(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [IDX_W-1:0] cmd_reg_a,
    input  logic [IDX_W-1:0] cmd_reg_b,
    input  logic [IDX_W-1:0] lkp1_reg,
    output logic [IDX_W-1:0] lkp1_mapped,
    input  logic [IDX_W-1:0] lkp2_reg,
    output logic [IDX_W-1:0] lkp2_mapped,
    output logic             busy,
    output logic [CNT_W-1:0] swap_count
);
    typedef enum logic [1:0] {
        OP_SWAP    = 2'b00,
        OP_SAVE    = 2'b01,
        OP_RESTORE = 2'b10,
        OP_CLEAR   = 2'b11
    } cmd_op_e;

    typedef struct packed {
        cmd_op_e          op;
        logic [IDX_W-1:0] a;
        logic [IDX_W-1:0] b;
    } cmd_t;

    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } state_e;

    state_e state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    cmd_t cmd;
    logic accept, do_swap, do_save, do_restore, do_clear;

    logic [NUM_REGS-1:0][IDX_W-1:0] tbl;
    logic [NUM_REGS-1:0][IDX_W-1:0] ckpt;

    assign cmd        = '{op: cmd_op_e'(cmd_op), a: cmd_reg_a, b: cmd_reg_b};
    assign cmd_ready  = (state == IDLE);
    assign busy       = (state == CLEARING);
    assign accept     = cmd_valid && cmd_ready;
    // A self-swap is accepted but neither moves data nor counts.
    assign do_swap    = accept && (cmd.op == OP_SWAP) && (cmd.a != cmd.b);
    assign do_save    = accept && (cmd.op == OP_SAVE);
    assign do_restore = accept && (cmd.op == OP_RESTORE);
    assign do_clear   = accept && (cmd.op == OP_CLEAR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (do_clear) begin
                    state_nxt = CLEARING;
                    ptr_nxt   = '0;
                end
            end
            CLEARING: begin
                ptr_nxt = ptr + IDX_W'(1);
                if (ptr == IDX_W'(NUM_REGS - 1)) begin
                    state_nxt = IDLE;
                    ptr_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            swap_count <= '0;
        else if (do_swap && (swap_count != {CNT_W{1'b1}}))
            swap_count <= swap_count + CNT_W'(1);
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
        logic             we;
        logic [IDX_W-1:0] d;

        // Both swap sides read pre-edge table values, so the exchange is atomic.
        always_comb begin
            we = 1'b0;
            d  = tbl[i];
            if (busy && (ptr == IDX_W'(i))) begin
                we = 1'b1;
                d  = IDX_W'(i);
            end else if (do_restore) begin
                we = 1'b1;
                d  = ckpt[i];
            end else if (do_swap && (cmd.a == IDX_W'(i))) begin
                we = 1'b1;
                d  = tbl[cmd.b];
            end else if (do_swap && (cmd.b == IDX_W'(i))) begin
                we = 1'b1;
                d  = tbl[cmd.a];
            end
        end

        register_mapper_entry #(
            .IDX_W     (IDX_W),
            .RESET_VAL (IDX_W'(i))
        ) u_entry (
            .clk     (clk),
            .reset   (reset),
            .tbl_we  (we),
            .tbl_d   (d),
            .ckpt_we (do_save),
            .tbl_q   (tbl[i]),
            .ckpt_q  (ckpt[i])
        );
    end

    assign lkp1_mapped = tbl[lkp1_reg];
    assign lkp2_mapped = tbl[lkp2_reg];
endmodule

// File: tb/tb_register_mapper_param.sv
// Directed bench for register_mapper_param: a default instance and a CNT_W=2
// instance share all stimulus, so the narrow counter saturation is seen alongside.

module tb_register_mapper_param;
    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic [1:0]    cmd_op;
    logic [IW-1:0] cmd_reg_a, cmd_reg_b, lkp1_reg, lkp2_reg;

    logic          cmd_ready, busy, cmd_ready_s, busy_s;
    logic [IW-1:0] lkp1_mapped, lkp2_mapped, lkp1_mapped_s, lkp2_mapped_s;
    logic [7:0]    swap_count;
    logic [1:0]    swap_count_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    register_mapper_param #(.NUM_REGS(N)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_reg_a(cmd_reg_a), .cmd_reg_b(cmd_reg_b),
        .lkp1_reg(lkp1_reg), .lkp1_mapped(lkp1_mapped),
        .lkp2_reg(lkp2_reg), .lkp2_mapped(lkp2_mapped),
        .busy(busy), .swap_count(swap_count)
    );

    register_mapper_param #(.NUM_REGS(N), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_s),
        .cmd_op(cmd_op), .cmd_reg_a(cmd_reg_a), .cmd_reg_b(cmd_reg_b),
        .lkp1_reg(lkp1_reg), .lkp1_mapped(lkp1_mapped_s),
        .lkp2_reg(lkp2_reg), .lkp2_mapped(lkp2_mapped_s),
        .busy(busy_s), .swap_count(swap_count_s)
    );

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Walks both lookup ports (port 2 in reverse) over the whole table of both instances.
    task automatic chk_tbl(input string tag, input int e0, input int e1, input int e2, input int e3);
        int exp [N];
        exp = '{e0, e1, e2, e3};
        for (int i = 0; i < N; i++) begin
            lkp1_reg = IW'(i);
            lkp2_reg = IW'(N - 1 - i);
            #1;
            chk($sformatf("%s lkp1[%0d]", tag, i), lkp1_mapped, exp[i]);
            chk($sformatf("%s lkp2[%0d]", tag, N - 1 - i), lkp2_mapped, exp[N - 1 - i]);
            chk($sformatf("%s narrow lkp1[%0d]", tag, i), lkp1_mapped_s, exp[i]);
        end
    endtask

    // Presents one command for a single edge; called at posedge+1.
    task automatic do_cmd(input logic [1:0] op, input int a, input int b);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_reg_a = IW'(a);
        cmd_reg_b = IW'(b);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    initial begin
        int busy_cycles;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00;
        cmd_reg_a = '0; cmd_reg_b = '0; lkp1_reg = '0; lkp2_reg = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("reset ready", cmd_ready, 1);
        chk("reset busy", busy, 0);
        chk("reset count", swap_count, 0);
        chk_tbl("reset", 0, 1, 2, 3);

        // No bypass: the table is unchanged until the accepting edge.
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_reg_a = 2'd1; cmd_reg_b = 2'd3;
        lkp1_reg = 2'd1; #1;
        chk("swap13 pre-edge", lkp1_mapped, 1);
        @(posedge clk); #1; cmd_valid = 1'b0;
        chk_tbl("swap13", 0, 3, 2, 1);
        chk("swap13 count", swap_count, 1);

        do_cmd(2'b00, 0, 1);
        chk_tbl("swap01", 3, 0, 2, 1);
        chk("swap01 count", swap_count, 2);

        do_cmd(2'b00, 2, 2);
        chk_tbl("swap22", 3, 0, 2, 1);
        chk("swap22 count", swap_count, 2);
        chk("swap22 ready", cmd_ready, 1);

        do_cmd(2'b01, 0, 0);
        do_cmd(2'b00, 0, 3);
        chk_tbl("swap03", 1, 0, 2, 3);
        chk("swap03 count", swap_count, 3);
        do_cmd(2'b10, 0, 0);
        chk_tbl("restore", 3, 0, 2, 1);
        chk("restore count", swap_count, 3);

        // CLEAR with a SWAP(0,3) held valid throughout the walk.
        do_cmd(2'b11, 0, 0);
        chk("clear busy", busy, 1);
        chk("clear ready", cmd_ready, 0);
        lkp1_reg = 2'd0; lkp2_reg = 2'd3; #1;
        chk("clear t0 entry0", lkp1_mapped, 3);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_reg_a = 2'd0; cmd_reg_b = 2'd3;
        busy_cycles = 1;
        @(posedge clk); #1;
        chk("clear t1 entry0", lkp1_mapped, 0);
        chk("clear t1 entry3", lkp2_mapped, 1);
        while (busy && busy_cycles < 20) begin
            busy_cycles++;
            @(posedge clk); #1;
        end
        chk("clear busy cycles", busy_cycles, 4);
        chk("clear held count", swap_count, 3);
        chk_tbl("cleared", 0, 1, 2, 3);
        @(posedge clk); #1; cmd_valid = 1'b0;
        chk_tbl("held swap", 3, 1, 2, 0);
        chk("held swap count", swap_count, 4);
        chk("narrow count sat", swap_count_s, 3);

        do_cmd(2'b00, 1, 2);
        chk_tbl("swap12", 3, 2, 1, 0);
        chk("swap12 count", swap_count, 5);
        chk("narrow count hold", swap_count_s, 3);

        // Asynchronous reset in the middle of a CLEAR walk.
        do_cmd(2'b11, 0, 0);
        @(posedge clk); #3;
        reset = 1'b1; #1;
        chk("midclr rst busy", busy, 0);
        chk("midclr rst busy narrow", busy_s, 0);
        chk("midclr rst ready", cmd_ready, 1);
        chk("midclr rst count", swap_count, 0);
        chk_tbl("midclr rst", 0, 1, 2, 3);
        @(posedge clk); #1 reset = 1'b0;

        do_cmd(2'b10, 0, 0);
        chk_tbl("restore after rst", 0, 1, 2, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
